// File: rtl/motoro_uart_cmd_rx.sv
// rtl/motoro_uart_cmd_rx.sv - 8N1 serial command receiver driving motor start/invert/frequency controls
// Define MOTORO_CMD_CHKSUM_EN to require a trailing XOR checksum byte on every frame.
module motoro_uart_cmd_rx #(
   parameter int unsigned CLK_DIV      = 434,
   parameter int unsigned TIMEOUT_BITS = 20,
   parameter logic [9:0]  FREQ_RST     = 10'd0
) (
   input  logic       clk50mhz,
   input  logic       nReset,
   input  logic       rs232_rx,
   output logic [9:0] m3freq,
   output logic       m3freqLoad,
   output logic       m3start,
   output logic       m3invOrStop,
   output logic       cmdErr,
   output logic [7:0] rxByte,
   output logic       rxValid
);
   localparam int unsigned HALF     = CLK_DIV / 2;
   localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLK_DIV;
   localparam int unsigned BW       = $clog2(CLK_DIV);
   localparam int unsigned TW       = $clog2(TO_LIMIT);
   localparam logic [7:0]  CMD_S    = 8'h53;
   localparam logic [7:0]  CMD_I    = 8'h49;
   localparam logic [7:0]  CMD_F    = 8'h46;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {P_CMD, P_FHI, P_FLO, P_CHK} p_state_t;

   logic          r_sync1, r_sync2, r_sync_d;
   logic          w_fall;
   rx_state_t     r_rx_state, w_rx_next;
   logic [BW-1:0] r_bit_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_brk;
   logic          w_half_tick, w_bit_tick, w_sample, w_stop_ok, w_frame_err;
   logic          r_rx_valid;
   logic [7:0]    r_rx_byte;

   p_state_t      r_p_state, w_p_next;
   logic [1:0]    r_freq_hi;
`ifdef MOTORO_CMD_CHKSUM_EN
   logic [7:0]    r_freq_lo, r_chk, r_pend;
`endif
   logic          w_start, w_inv, w_load, w_proto_err;
   logic [9:0]    w_commit;
   logic [TW-1:0] r_to_cnt;
   logic          w_to_run, w_timeout;
   logic          r_m3start, r_m3inv, r_m3load, r_cmd_err;
   logic [9:0]    r_m3freq;

   always_ff @(posedge clk50mhz or negedge nReset) begin
      if (!nReset) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_sync_d <= 1'b1;
      end else begin
         r_sync1  <= rs232_rx;
         r_sync2  <= r_sync1;
         r_sync_d <= r_sync2;
      end
   end

   assign w_fall      = r_sync_d & ~r_sync2;
   assign w_half_tick = (r_bit_cnt == BW'(HALF - 1));
   assign w_bit_tick  = (r_bit_cnt == BW'(CLK_DIV - 1));

   always_ff @(posedge clk50mhz or negedge nReset) begin
      if (!nReset) r_rx_state <= RX_IDLE;
      else         r_rx_state <= w_rx_next;
   end

   // After a framing error r_brk holds RX_STOP until the line idles high again.
   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         RX_IDLE:  if (w_fall) w_rx_next = RX_START;
         RX_START: if (w_half_tick) w_rx_next = r_sync2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_bit_tick && r_bit_idx == 3'd7) w_rx_next = RX_STOP;
         RX_STOP: begin
            if (r_brk) begin
               if (r_sync2) w_rx_next = RX_IDLE;
            end else if (w_bit_tick && r_sync2) begin
               w_rx_next = RX_IDLE;
            end
         end
         default:  w_rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      w_sample    = 1'b0;
      w_stop_ok   = 1'b0;
      w_frame_err = 1'b0;
      case (r_rx_state)
         RX_DATA: w_sample = w_bit_tick;
         RX_STOP: begin
            if (!r_brk && w_bit_tick) begin
               w_stop_ok   = r_sync2;
               w_frame_err = ~r_sync2;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk50mhz or negedge nReset) begin
      if (!nReset) begin
         r_bit_cnt  <= '0;
         r_bit_idx  <= 3'd0;
         r_shift    <= 8'h00;
         r_brk      <= 1'b0;
         r_rx_valid <= 1'b0;
         r_rx_byte  <= 8'h00;
      end else begin
         if (r_rx_state == RX_IDLE || w_rx_next != r_rx_state || w_bit_tick)
            r_bit_cnt <= '0;
         else
            r_bit_cnt <= r_bit_cnt + 1'b1;
         if (r_rx_state != RX_DATA) r_bit_idx <= 3'd0;
         else if (w_sample)         r_bit_idx <= r_bit_idx + 3'd1;
         if (w_sample) r_shift <= {r_sync2, r_shift[7:1]};
         if (w_frame_err)                r_brk <= 1'b1;
         else if (w_rx_next == RX_IDLE) r_brk <= 1'b0;
         r_rx_valid <= w_stop_ok;
         if (w_stop_ok) r_rx_byte <= r_shift;
      end
   end

   always_ff @(posedge clk50mhz or negedge nReset) begin
      if (!nReset) r_p_state <= P_CMD;
      else         r_p_state <= w_p_next;
   end

   always_comb begin
      w_p_next = r_p_state;
      if (w_frame_err || w_timeout) begin
         w_p_next = P_CMD;
      end else if (r_rx_valid) begin
         case (r_p_state)
`ifdef MOTORO_CMD_CHKSUM_EN
            P_CMD: begin
               if (r_rx_byte == CMD_F)                           w_p_next = P_FHI;
               else if (r_rx_byte == CMD_S || r_rx_byte == CMD_I) w_p_next = P_CHK;
            end
            P_FLO:   w_p_next = P_CHK;
`else
            P_CMD:   if (r_rx_byte == CMD_F) w_p_next = P_FHI;
            P_FLO:   w_p_next = P_CMD;
`endif
            P_FHI:   w_p_next = (r_rx_byte[7:2] == 6'd0) ? P_FLO : P_CMD;
            default: w_p_next = P_CMD;
         endcase
      end
   end

   always_comb begin
      w_start     = 1'b0;
      w_inv       = 1'b0;
      w_load      = 1'b0;
      w_proto_err = 1'b0;
`ifdef MOTORO_CMD_CHKSUM_EN
      w_commit    = {r_freq_hi, r_freq_lo};
`else
      w_commit    = {r_freq_hi, r_rx_byte};
`endif
      if (r_rx_valid && !w_timeout) begin
         case (r_p_state)
            P_CMD: begin
`ifndef MOTORO_CMD_CHKSUM_EN
               w_start = (r_rx_byte == CMD_S);
               w_inv   = (r_rx_byte == CMD_I);
`endif
               w_proto_err = (r_rx_byte != CMD_S) && (r_rx_byte != CMD_I) && (r_rx_byte != CMD_F);
            end
            P_FHI: w_proto_err = |r_rx_byte[7:2];
`ifdef MOTORO_CMD_CHKSUM_EN
            P_CHK: begin
               if (r_rx_byte == r_chk) begin
                  w_start = (r_pend == CMD_S);
                  w_inv   = (r_pend == CMD_I);
                  w_load  = (r_pend == CMD_F);
               end else begin
                  w_proto_err = 1'b1;
               end
            end
`else
            P_FLO: w_load = 1'b1;
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk50mhz or negedge nReset) begin
      if (!nReset) begin
         r_freq_hi <= 2'd0;
`ifdef MOTORO_CMD_CHKSUM_EN
         r_freq_lo <= 8'h00;
         r_chk     <= 8'h00;
         r_pend    <= 8'h00;
`endif
      end else if (r_rx_valid) begin
         if (r_p_state == P_FHI) r_freq_hi <= r_rx_byte[1:0];
`ifdef MOTORO_CMD_CHKSUM_EN
         if (r_p_state == P_CMD) begin
            r_chk  <= r_rx_byte;
            r_pend <= r_rx_byte;
         end else if (r_p_state == P_FHI || r_p_state == P_FLO) begin
            r_chk  <= r_chk ^ r_rx_byte;
         end
         if (r_p_state == P_FLO) r_freq_lo <= r_rx_byte;
`endif
      end
   end

   // Inter-byte timeout only counts idle line time inside an unfinished frame.
   assign w_to_run   = (r_p_state != P_CMD) && (r_rx_state == RX_IDLE);
   assign w_timeout  = w_to_run && (r_to_cnt == TW'(TO_LIMIT - 1));

   always_ff @(posedge clk50mhz or negedge nReset) begin
      if (!nReset) begin
         r_to_cnt  <= '0;
         r_m3start <= 1'b0;
         r_m3inv   <= 1'b0;
         r_m3load  <= 1'b0;
         r_cmd_err <= 1'b0;
         r_m3freq  <= FREQ_RST;
      end else begin
         if (!w_to_run || w_timeout || w_fall) r_to_cnt <= '0;
         else                                  r_to_cnt <= r_to_cnt + 1'b1;
         r_m3start <= w_start;
         r_m3inv   <= w_inv;
         r_m3load  <= w_load;
         r_cmd_err <= w_frame_err | w_timeout | w_proto_err;
         if (w_load) r_m3freq <= w_commit;
      end
   end

   assign m3freq      = r_m3freq;
   assign m3freqLoad  = r_m3load;
   assign m3start     = r_m3start;
   assign m3invOrStop = r_m3inv;
   assign cmdErr      = r_cmd_err;
   assign rxByte      = r_rx_byte;
   assign rxValid     = r_rx_valid;
endmodule

// File: tb/tb_motoro_uart_cmd_rx.sv
// tb/tb_motoro_uart_cmd_rx.sv - randomized frame-level bench for motoro_uart_cmd_rx
module tb_motoro_uart_cmd_rx;
   localparam int unsigned CLK_DIV      = 8;
   localparam int unsigned TIMEOUT_BITS = 4;
   localparam logic [9:0]  FREQ_RST     = 10'h133;
`ifdef MOTORO_CMD_CHKSUM_EN
   localparam int CHK = 1;
`else
   localparam int CHK = 0;
`endif

   logic       clk50mhz = 1'b0;
   logic       nReset   = 1'b0;
   logic       rs232_rx = 1'b1;
   logic [9:0] m3freq;
   logic       m3freqLoad, m3start, m3invOrStop, cmdErr, rxValid;
   logic [7:0] rxByte;

   motoro_uart_cmd_rx #(.CLK_DIV(CLK_DIV), .TIMEOUT_BITS(TIMEOUT_BITS), .FREQ_RST(FREQ_RST)) dut (
      .clk50mhz(clk50mhz), .nReset(nReset), .rs232_rx(rs232_rx),
      .m3freq(m3freq), .m3freqLoad(m3freqLoad), .m3start(m3start),
      .m3invOrStop(m3invOrStop), .cmdErr(cmdErr), .rxByte(rxByte), .rxValid(rxValid)
   );

   always #5 clk50mhz = ~clk50mhz;

   int n_total = 0, n_bad = 0;
   int cyc = 0, last_rxv = -10;
   int n_rxv = 0, n_start = 0, n_inv = 0, n_load = 0, n_err = 0;
   int e_rxv = 0, e_start = 0, e_inv = 0, e_load = 0, e_err = 0;
   logic [9:0] e_freq = FREQ_RST;
   logic [7:0] exp_bytes[$];
   logic [7:0] fq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk50mhz) cyc <= cyc + 1;

   always @(negedge clk50mhz) begin
      if (rxValid) begin
         last_rxv = cyc;
         n_rxv++;
         check("rx_expected", 32'(exp_bytes.size() > 0), 1);
         if (exp_bytes.size() > 0) check("rx_byte", rxByte, exp_bytes.pop_front());
      end
      if (m3start)     begin n_start++; check("start_lat", cyc, last_rxv + 1); end
      if (m3invOrStop) begin n_inv++;   check("inv_lat",   cyc, last_rxv + 1); end
      if (m3freqLoad)  begin n_load++;  check("load_lat",  cyc, last_rxv + 1); end
      if (cmdErr) n_err++;
   end

   // Frame-level reference: collect bytes of the current frame, judge it when complete.
   function automatic int frame_len(input logic [7:0] c);
      return (c == 8'h46) ? 3 + CHK : 1 + CHK;
   endfunction

   task automatic model_byte(input logic [7:0] b);
      logic [7:0] x;
      fq.push_back(b);
      if (fq[0] != 8'h53 && fq[0] != 8'h49 && fq[0] != 8'h46) begin
         e_err++; fq.delete(); return;
      end
      if (fq[0] == 8'h46 && fq.size() == 2 && b[7:2] != 6'd0) begin
         e_err++; fq.delete(); return;
      end
      if (fq.size() < frame_len(fq[0])) return;
      if (CHK == 1) begin
         x = 8'h00;
         for (int i = 0; i < fq.size() - 1; i++) x = x ^ fq[i];
         if (x != fq[fq.size() - 1]) begin e_err++; fq.delete(); return; end
      end
      if (fq[0] == 8'h53)      e_start++;
      else if (fq[0] == 8'h49) e_inv++;
      else begin e_load++; e_freq = {fq[1][1:0], fq[2]}; end
      fq.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      if (stop_bit) begin exp_bytes.push_back(b); e_rxv++; end
      for (int i = 0; i < 10; i++) begin
         rs232_rx = fr[i];
         repeat (CLK_DIV) @(negedge clk50mhz);
      end
      if (stop_bit) model_byte(b);
      else begin e_err++; fq.delete(); end
   endtask

   task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
      logic [7:0] bs[3];
      logic [7:0] x;
      bs[0] = b0; bs[1] = b1; bs[2] = b2;
      x = 8'h00;
      for (int i = 0; i < n; i++) begin send_byte(bs[i], 1'b1); x = x ^ bs[i]; end
      if (CHK == 1) send_byte(x, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk50mhz);
      if (n >= 40 && fq.size() > 0) begin e_err++; fq.delete(); end
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_rxv"},   n_rxv,   e_rxv);
      check({tag, "_start"}, n_start, e_start);
      check({tag, "_inv"},   n_inv,   e_inv);
      check({tag, "_load"},  n_load,  e_load);
      check({tag, "_err"},   n_err,   e_err);
      check({tag, "_freq"},  m3freq,  e_freq);
   endtask

   initial begin
      int sel;
      logic [7:0] hi;
      // 1: reset with a toggling line
      for (int i = 0; i < 20; i++) begin
         rs232_rx = 1'($urandom_range(0, 1));
         @(negedge clk50mhz);
      end
      check("rst_freq", m3freq, FREQ_RST);
      check("rst_pulses", {m3freqLoad, m3start, m3invOrStop, cmdErr, rxValid}, 5'b0);
      check("rst_rxbyte", rxByte, 8'h00);
      rs232_rx = 1'b1;
      @(negedge clk50mhz);
      nReset = 1'b1;
      idle(30);
      check_counts("post_rst");

      // 2: frequency frame
      send_frame(8'h46, 8'h02, 8'h5A, 3);
      idle(5);
      check("freq_25a", m3freq, 10'h25A);
      check_counts("freq");
`ifdef MOTORO_CMD_CHKSUM_EN
      send_byte(8'h46, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h11, 1'b1); send_byte(8'h00, 1'b1);
      idle(5);
      check("freq_badchk", m3freq, 10'h25A);
      check_counts("badchk");
`endif

      // 3: back-to-back S then I
      send_frame(8'h53, 8'h00, 8'h00, 1);
      send_frame(8'h49, 8'h00, 8'h00, 1);
      idle(5);
      check_counts("s_i");

      // 4: bad high byte, unknown command, then recovery
      send_byte(8'h46, 1'b1); send_byte(8'h04, 1'b1);
      idle(5);
      check_counts("bad_hi");
      send_byte(8'h58, 1'b1);
      idle(5);
      check_counts("bad_cmd");
      send_frame(8'h53, 8'h00, 8'h00, 1);
      idle(5);
      check_counts("recover");

      // 5: glitch, then framing error with the line held low
      rs232_rx = 1'b0;
      repeat (3) @(negedge clk50mhz);
      rs232_rx = 1'b1;
      idle(30);
      check_counts("glitch");
      send_byte(8'hA5, 1'b0);
      idle(30);
      check_counts("frame_err");
      rs232_rx = 1'b1;
      idle(5);
      send_frame(8'h53, 8'h00, 8'h00, 1);
      idle(5);
      check_counts("rearm");

      // 6: timeout, then reset mid-frame
      send_byte(8'h46, 1'b1); send_byte(8'h01, 1'b1);
      idle(40);
      check_counts("timeout");
      send_frame(8'h53, 8'h00, 8'h00, 1);
      idle(5);
      check_counts("post_to");
      send_byte(8'h46, 1'b1); send_byte(8'h01, 1'b1);
      nReset = 1'b0;
      repeat (3) @(negedge clk50mhz);
      nReset = 1'b1;
      fq.delete();
      e_freq = FREQ_RST;
      check("midrst_freq", m3freq, FREQ_RST);
      send_byte(8'h5A, 1'b1);
      idle(5);
      check_counts("mid_rst");

      // randomized token stream
      for (int t = 0; t < 120; t++) begin
         sel = int'($urandom_range(0, 7));
         case (sel)
            0: send_frame(8'h53, 8'h00, 8'h00, 1);
            1: send_frame(8'h49, 8'h00, 8'h00, 1);
            2, 3: begin
               hi = 8'($urandom_range(0, 3));
               send_frame(8'h46, hi, 8'($urandom_range(0, 255)), 3);
            end
            4: send_byte(8'h46, 1'b1);
            5: send_byte(8'($urandom_range(0, 3)), 1'b1);
            default: send_byte(8'($urandom_range(0, 255)), 1'b1);
         endcase
         if ($urandom_range(0, 5) == 0) begin
            idle(40);
            check_counts("rnd");
         end else begin
            idle(int'($urandom_range(0, 3)));
         end
      end
      idle(50);
      check_counts("final");
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/motoro_uart_cmd_rx.md
# motoro_uart_cmd_rx

Serial command receiver for the three-phase motor driver. It receives 8N1 RS-232 bytes on `rs232_rx`, decodes them into motor commands, and drives the `m3start`, `m3invOrStop` and `m3freq` control inputs of the motor top level. It is the host-to-board counterpart of the existing `rs232_tx` status path. It sits between the board RX pin and the motor core, in the `clk50mhz` domain.

## Interface
Parameters:
- `CLK_DIV`, 434: clocks per bit (50 MHz / 115200). Minimum 4.
- `TIMEOUT_BITS`, 20: bit-times of idle line allowed inside an incomplete frame.
- `FREQ_RST`, 10'd0: reset value of `m3freq`.

Ports (one clock; reset is asynchronous and active-low):
- `clk50mhz` in 1: system clock, rising edge.
- `nReset` in 1: asynchronous active-low reset.
- `rs232_rx` in 1: asynchronous serial input, idles high.
- `m3freq` out 10: held frequency set-point.
- `m3freqLoad` out 1: one-cycle pulse when `m3freq` updates.
- `m3start` out 1: one-cycle start pulse.
- `m3invOrStop` out 1: one-cycle invert/stop pulse.
- `cmdErr` out 1: one-cycle pulse on any framing, protocol, checksum or timeout error.
- `rxByte` out 8: last received byte (debug/tp).
- `rxValid` out 1: one-cycle pulse with each good byte.

## Operation
- **Input synchronizer:** 2-flop synchronizer on `rs232_rx`, reset to 1. All sampling uses the synchronized value.
- **Byte receiver FSM** (RX_IDLE, RX_START, RX_DATA, RX_STOP):
  - RX_IDLE → RX_START on a synchronized falling edge.
  - RX_START waits CLK_DIV/2 (floor) cycles. If the line is high at that point, it is a false start: return to RX_IDLE with no error. Otherwise go to RX_DATA.
  - RX_DATA samples 8 bits, LSB first, one every CLK_DIV cycles.
  - RX_STOP samples one CLK_DIV later:
    - Stop bit = 1: register the byte, pulse `rxValid`, return to RX_IDLE.
    - Stop bit = 0: pulse `cmdErr`, discard the byte, reset the parser, and wait in RX_STOP until the line is high before going to RX_IDLE.
- **Frame parser FSM** (P_CMD, P_FHI, P_FLO, P_CHK), advanced by each `rxValid`:
  - P_CMD, byte 0x53 'S': issue `m3start`.
  - P_CMD, byte 0x49 'I': issue `m3invOrStop`.
  - P_CMD, byte 0x46 'F': go to P_FHI.
  - P_CMD, any other byte: `cmdErr`, stay in P_CMD.
  - P_FHI: bits [7:2] must be 0, otherwise `cmdErr` and return to P_CMD. If valid, latch bits [1:0] as freq[9:8] into a shadow register and go to P_FLO.
  - P_FLO: latch freq[7:0] into the shadow register, then commit, or go to P_CHK when the checksum feature is built in.
  - Commit for 'F': `m3freq` ← shadow and `m3freqLoad` pulses in the same cycle. `m3freq` never changes on a rejected frame.
- **Inter-byte timeout:** a counter runs while the parser is not in P_CMD and the receiver is in RX_IDLE. At TIMEOUT_BITS×CLK_DIV cycles it pulses `cmdErr` and returns the parser to P_CMD. The counter clears on every start edge.
- **Precedence:** a framing error in the same cycle as a timeout produces a single `cmdErr` pulse.
- **Reset mid-byte or mid-frame:** both FSMs return to idle and the partial frame is lost.

## Timing
- Reset values:
  - `m3freq` = FREQ_RST.
  - All pulse outputs = 0.
  - `rxByte` = 0.
  - Synchronizer flops = 1.
  - Both FSMs idle.
- Data bit k is sampled CLK_DIV/2 + (k+1)×CLK_DIV cycles after the synchronized start edge. The stop bit is sampled at CLK_DIV/2 + 9×CLK_DIV.
- `rxValid` and `rxByte` are registered 1 cycle after the stop-bit sample.
- Command outputs (`m3start`, `m3invOrStop`, `m3freqLoad`/`m3freq`, `cmdErr` for protocol errors) assert 1 cycle after `rxValid`.
- Every pulse output is high for exactly one cycle.
- The block accepts back-to-back bytes with no idle gap: a new start edge is accepted in the cycle after the stop sample.

## Configuration
- `MOTORO_CMD_CHKSUM_EN` defined:
  - Every frame carries a trailing checksum byte, parsed in P_CHK.
  - Checksum = XOR of all preceding bytes of the frame. For 'S' the checksum is 0x53; for 'I' it is 0x49.
  - Commands issue only after a matching checksum. A mismatch pulses `cmdErr`, discards the frame, and returns the parser to P_CMD.
- Not defined:
  - P_CHK is absent.
  - 'S' and 'I' act immediately in P_CMD; 'F' commits from P_FLO.

## Test plan
All scenarios use CLK_DIV=8, TIMEOUT_BITS=4 and a clean 8N1 stimulus unless stated.
1. Hold `nReset`=0 with the line toggling → all outputs at reset values and `m3freq`=FREQ_RST. Release reset → no spurious pulses.
2. Send 0x46, 0x02, 0x5A → `m3freq`=0x25A with one `m3freqLoad` pulse 1 cycle after the third `rxValid`. Under the macro, append 0x1E and expect the same result; append 0x00 instead and expect `cmdErr` with `m3freq` unchanged.
3. Send 'S' then 'I' back-to-back → one `m3start` pulse, then one `m3invOrStop` pulse, each 1 cycle after its `rxValid`.
4. Send 0x46, 0x04 → `cmdErr` and `m3freq` unchanged. Then send 0x58 → `cmdErr`. Then 'S' → `m3start`.
5. Drive a 3-cycle low glitch → no `rxValid` and no `cmdErr`. Send a byte with stop bit 0 → `cmdErr`, no `rxValid`, and the line is re-armed only after it returns high.
6. Send 0x46, 0x01, then idle for 40 cycles → `cmdErr` once at the timeout. A following 'S' produces `m3start`. Assert reset mid-'F' frame → the parser returns to P_CMD.
